nn_ram_arbiter: RTL and testbench
=================================

Name: nn_ram_arbiter

Overview:
Shares the single-port nnRvSoc data RAM between three requesters: CPU instruction fetch (IF), CPU load/store unit (LS), and the VGA sprite/video fetch (VD, read-only).
- Round-robin arbitration with a simple req/ack handshake per port.
- One transaction in flight at a time.
- Sits between the nnRvSoc core and the RAM array, in the CPU clock domain (CLK, the divided clock).

Parameters:
RAM_AW, 14, RAM word-address width; ram_addr = port addr[RAM_AW+1:2].
RAM_LAT, 1, RAM read latency in cycles from ram_en to valid ram_rdata (range 1..4).

Ports:
CLK  in  1  CPU clock; all logic on posedge.
RST_N  in  1  reset, synchronous, active-low.
if_req  in  1  IF read request; held until if_ack.
if_addr  in  32  IF byte address.
if_ack  out  1  one-cycle pulse; IF transaction done.
if_rdata  out  32  IF read data, valid while if_ack=1 and held until the next IF read.
ls_req  in  1  LS request; held until ls_ack.
ls_we  in  1  LS write enable.
ls_wstrb  in  4  LS byte strobes (writes only).
ls_addr  in  32  LS byte address.
ls_wdata  in  32  LS write data.
ls_ack  out  1  one-cycle pulse; LS transaction done.
ls_rdata  out  32  LS read data; same validity rule as if_rdata.
vd_req  in  1  video read request.
vd_addr  in  32  video byte address.
vd_ack  out  1  one-cycle pulse.
vd_rdata  out  32  video read data; same validity rule.
ram_en  out  1  RAM access strobe, registered.
ram_we  out  4  RAM byte write enables, registered; 0000 for reads.
ram_addr  out  RAM_AW  RAM word address, registered.
ram_wdata  out  32  RAM write data, registered.
ram_rdata  in  32  RAM read data, valid RAM_LAT cycles after ram_en.

Behaviour:
- Reset (RST_N=0 at posedge):
  - State IDLE; all acks 0; ram_en 0; ram_we 0; ram_addr 0; ram_wdata 0; all rdata 0.
  - Round-robin pointer last=2 (VD), so IF has first priority after reset.
- State machine: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE:
  - Samples all reqs.
  - If any req is high, pick a winner in order last+1, last+2, last (mod 3).
  - Latch owner; set last=owner.
  - Register the owner's addr, we, wstrb and wdata onto the ram_* outputs; go to ISSUE.
- ISSUE: ram_en=1 for exactly this cycle; load counter=RAM_LAT-1; go to WAIT.
- WAIT:
  - ram_en=0, ram_we=0.
  - Decrement counter; at 0, capture ram_rdata into the owner's rdata register (reads only; writes leave rdata unchanged); go to ACK.
- ACK: owner's ack=1 for one cycle; all reqs are ignored this cycle; next state IDLE.
- Latency: req first seen high in IDLE at cycle T -> ram_en at T+1 -> ack at T+RAM_LAT+2. Peak throughput is one transaction per RAM_LAT+3 cycles.
- Requester rule: drop req, or present a new request, in the cycle after ack. A req still high in IDLE is a new request.
- req dropped mid-transaction: the transaction still completes and ack still pulses; nothing is cancelled.
- Simultaneous requests: exactly one grant; the other requests wait with no loss.
- Starvation bound: a pending port is served within 2 foreign transactions.
- Address bits [1:0] and [31:RAM_AW+2] are ignored; addresses wrap modulo 2^RAM_AW words.
- ls_wstrb=0000 with ls_we=1: ram_en still pulses with ram_we=0000; ack issued normally.
- Reset mid-operation:
  - Next cycle is IDLE with all outputs at reset values; the in-flight ack is never issued.
  - A write issued in ISSUE before reset is allowed to have committed.

Optional Feature:
NN_ARB_LS_PRIO_EN
- Defined: LS wins in IDLE whenever ls_req=1, and last is not updated by LS grants. IF/VD use round-robin between themselves, and can starve under a continuous LS load.
- Undefined: pure 3-way round-robin as above.

Decomposition:
- Package nn_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, ACK);
  - port index constants PORT_IF=0, PORT_LS=1, PORT_VD=2;
  - NPORT=3.
- Sub-module nn_rr_pick: combinational 3-way rotating-priority picker.
  - Inputs: req vector and last.
  - Outputs: one-hot grant and index.
  - Reused by the SoC's future MMIO arbiter.

Test Plan:
1. RAM_LAT=1, single IF read at 0x100, mem[0x40]=0x12345678 -> ram_en=1 with ram_addr=0x40 one cycle after req; if_ack 3 cycles after req; if_rdata=0x12345678.
2. After reset, if_req, ls_req and vd_req all held high with immediate re-requests -> grant order IF, LS, VD, IF, LS, VD; each ack a single-cycle pulse.
3. LS write 0xDEADBEEF, wstrb=0011 to 0x8 over mem[2]=0 -> ram_we=0011, ram_addr=2; then LS read of 0x8 returns ls_rdata=0x0000BEEF; if_rdata unchanged.
4. RST_N low during WAIT (RAM_LAT=3) -> next cycle all acks 0, ram_en 0; then an LS+IF request pair is granted IF first.
5. NN_ARB_LS_PRIO_EN defined, ls_req and vd_req held high -> every grant goes to LS. Undefined -> LS and VD alternate.
6. RAM_LAT=3, VD read -> ack exactly 5 cycles after req; ram_rdata sampled only in the WAIT cycle where the counter reaches 0.

Source files
------------

// File: rtl/nn_ram_arbiter_pkg.sv
// Shared types and constants for the nnRvSoc data-RAM arbiter.
// Optional build macro used by the arbiter: NN_ARB_LS_PRIO_EN.
package nn_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int         NPORT   = 3;
    localparam logic [1:0] PORT_IF = 2'd0;
    localparam logic [1:0] PORT_LS = 2'd1;
    localparam logic [1:0] PORT_VD = 2'd2;

    // (p + step) mod 3 for p in 0..2 and step in 1..3
    function automatic logic [1:0] rr_next(input logic [1:0] p, input logic [1:0] step);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, step};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/nn_ram_arbiter_if.sv
// Requester and RAM-side signals of the data-RAM arbiter.
// slave = arbiter side, master = core/video/RAM side.
interface nn_ram_arbiter_if #(
    parameter int RAM_AW = 14
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [3:0]        ls_wstrb;
    logic [31:0]       ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_ack;
    logic [31:0]       ls_rdata;

    logic              vd_req;
    logic [31:0]       vd_addr;
    logic              vd_ack;
    logic [31:0]       vd_rdata;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // req/ack: a requester holds req (and its addr/data) until a one-cycle ack;
    // rdata is valid with ack and held until that port's next read completes.
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_wstrb, ls_addr, ls_wdata,
               vd_req, vd_addr, ram_rdata,
        output if_ack, if_rdata, ls_ack, ls_rdata, vd_ack, vd_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_wstrb, ls_addr, ls_wdata,
               vd_req, vd_addr, ram_rdata,
        input  if_ack, if_rdata, ls_ack, ls_rdata, vd_ack, vd_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/nn_ram_arbiter_rr_pick.sv
// Combinational 3-way rotating-priority picker: search order last+1, last+2, last.
module nn_rr_pick
    import nn_arb_pkg::*;
(
    input  logic [NPORT-1:0] i_req,
    input  logic [1:0]       i_last,
    output logic [NPORT-1:0] o_grant,
    output logic [1:0]       o_idx,
    output logic             o_valid
);
    logic [1:0] w_c1;
    logic [1:0] w_c2;

    assign w_c1 = rr_next(i_last, 2'd1);
    assign w_c2 = rr_next(i_last, 2'd2);

    always_comb begin
        o_valid = |i_req;
        o_idx   = i_last;
        if (i_req[w_c1]) begin
            o_idx = w_c1;
        end else if (i_req[w_c2]) begin
            o_idx = w_c2;
        end
        o_grant = o_valid ? (NPORT'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/nn_ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between IF, LS and VD.
// Define NN_ARB_LS_PRIO_EN to give LS absolute priority over IF/VD.
module nn_ram_arbiter
    import nn_arb_pkg::*;
#(
    parameter int RAM_AW  = 14,
    parameter int RAM_LAT = 1
)(
    input  logic            CLK,
    input  logic            RST_N,
    nn_ram_arbiter_if.slave bus,
    output state_t          o_dbg_state
);
    localparam logic [1:0] CNT_INIT = 2'(RAM_LAT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_owner;
    logic [1:0]        r_last;
    logic [1:0]        r_cnt;
    logic              r_write;
    logic              r_ram_en;
    logic [3:0]        r_ram_we;
    logic [RAM_AW-1:0] r_ram_addr;
    logic [31:0]       r_ram_wdata;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_ls_rdata;
    logic [31:0]       r_vd_rdata;

    logic [NPORT-1:0]  w_req;
    logic [NPORT-1:0]  w_pick_req;
    logic [NPORT-1:0]  w_pick_grant;
    logic [1:0]        w_pick_idx;
    logic              w_pick_valid;
    logic [1:0]        w_win_idx;
    logic              w_win_valid;
    logic              w_win_upd;
    logic [31:0]       w_sel_addr;
    logic              w_sel_we;
    logic              w_unused;

    assign w_req = {bus.vd_req, bus.ls_req, bus.if_req};

`ifdef NN_ARB_LS_PRIO_EN
    // LS bypasses the rotation and never moves the pointer, so IF/VD rotate only between themselves
    assign w_pick_req = {w_req[PORT_VD], 1'b0, w_req[PORT_IF]};

    always_comb begin
        w_win_idx   = w_pick_idx;
        w_win_valid = w_pick_valid;
        w_win_upd   = 1'b1;
        if (bus.ls_req) begin
            w_win_idx   = PORT_LS;
            w_win_valid = 1'b1;
            w_win_upd   = 1'b0;
        end
    end
`else
    assign w_pick_req  = w_req;
    assign w_win_idx   = w_pick_idx;
    assign w_win_valid = w_pick_valid;
    assign w_win_upd   = 1'b1;
`endif

    nn_rr_pick u_pick (
        .i_req   (w_pick_req),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_sel_addr = bus.if_addr;
        w_sel_we   = 1'b0;
        case (w_win_idx)
            PORT_LS: begin
                w_sel_addr = bus.ls_addr;
                w_sel_we   = bus.ls_we;
            end
            PORT_VD: w_sel_addr = bus.vd_addr;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_win_valid) w_next_state = ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (r_cnt == 2'd0) w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_owner     <= PORT_IF;
            r_last      <= PORT_VD;
            r_cnt       <= 2'd0;
            r_write     <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 4'b0000;
            r_ram_addr  <= '0;
            r_ram_wdata <= 32'h0;
            r_if_rdata  <= 32'h0;
            r_ls_rdata  <= 32'h0;
            r_vd_rdata  <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_owner     <= w_win_idx;
                        r_write     <= w_sel_we;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= w_sel_we ? bus.ls_wstrb : 4'b0000;
                        r_ram_addr  <= w_sel_addr[RAM_AW+1:2];
                        r_ram_wdata <= (w_win_idx == PORT_LS) ? bus.ls_wdata : 32'h0;
                        if (w_win_upd) r_last <= w_win_idx;
                    end
                end
                ISSUE: begin
                    r_ram_en <= 1'b0;
                    r_ram_we <= 4'b0000;
                    r_cnt    <= CNT_INIT;
                end
                WAIT: begin
                    if (r_cnt == 2'd0) begin
                        if (!r_write) begin
                            case (r_owner)
                                PORT_LS: r_ls_rdata <= bus.ram_rdata;
                                PORT_VD: r_vd_rdata <= bus.ram_rdata;
                                default: r_if_rdata <= bus.ram_rdata;
                            endcase
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.if_ack    = (r_state == ACK) && (r_owner == PORT_IF);
    assign bus.ls_ack    = (r_state == ACK) && (r_owner == PORT_LS);
    assign bus.vd_ack    = (r_state == ACK) && (r_owner == PORT_VD);
    assign bus.if_rdata  = r_if_rdata;
    assign bus.ls_rdata  = r_ls_rdata;
    assign bus.vd_rdata  = r_vd_rdata;
    assign bus.ram_en    = r_ram_en;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign o_dbg_state   = r_state;

    // byte-offset and above-range address bits carry no meaning for a word RAM
    assign w_unused = ^{bus.if_addr[31:RAM_AW+2], bus.if_addr[1:0],
                        bus.ls_addr[31:RAM_AW+2], bus.ls_addr[1:0],
                        bus.vd_addr[31:RAM_AW+2], bus.vd_addr[1:0], w_pick_grant};
endmodule

// File: tb/tb_nn_ram_arbiter.sv
// Directed bench for nn_ram_arbiter: one instance with RAM_LAT=1 and one with RAM_LAT=3.
module tb_nn_ram_arbiter;
    import nn_arb_pkg::*;

    localparam int AW = 14;

    logic   CLK = 1'b0;
    logic   RST_N;
    state_t st1;
    state_t st3;
    int     n_checks = 0;
    int     n_errors = 0;
    logic [1:0] exp_q[$];

    always #5 CLK = ~CLK;

    nn_ram_arbiter_if #(.RAM_AW(AW)) bus1 ();
    nn_ram_arbiter_if #(.RAM_AW(AW)) bus3 ();

    nn_ram_arbiter #(.RAM_AW(AW), .RAM_LAT(1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus1), .o_dbg_state(st1));
    nn_ram_arbiter #(.RAM_AW(AW), .RAM_LAT(3)) u_dut3 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus3), .o_dbg_state(st3));

    function automatic logic [31:0] init_word(input int i);
        case (i)
            'h40:    return 32'h1234_5678;
            2:       return 32'h0;
            5:       return 32'hCAFE_F00D;
            default: return 32'hA5A5_0000 | 32'(i);
        endcase
    endfunction

    // RAM models; read data is poisoned outside its valid cycle
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] rd1_q;
    logic        rd1_v;
    logic [31:0] s3_0, s3_1, s3_2;
    logic        v3_0, v3_1, v3_2;

    always @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
            rd1_v <= 1'b0;
        end else begin
            rd1_v <= bus1.ram_en;
            if (bus1.ram_en) begin
                rd1_q <= mem1[bus1.ram_addr[7:0]];
                for (int b = 0; b < 4; b++)
                    if (bus1.ram_we[b]) mem1[bus1.ram_addr[7:0]][8*b +: 8] <= bus1.ram_wdata[8*b +: 8];
            end
        end
    end

    always @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 256; i++) mem3[i] <= init_word(i);
            {v3_0, v3_1, v3_2} <= 3'b000;
        end else begin
            v3_0 <= bus3.ram_en;
            v3_1 <= v3_0;
            v3_2 <= v3_1;
            s3_1 <= s3_0;
            s3_2 <= s3_1;
            if (bus3.ram_en) begin
                s3_0 <= mem3[bus3.ram_addr[7:0]];
                for (int b = 0; b < 4; b++)
                    if (bus3.ram_we[b]) mem3[bus3.ram_addr[7:0]][8*b +: 8] <= bus3.ram_wdata[8*b +: 8];
            end
        end
    end

    assign bus1.ram_rdata = rd1_v ? rd1_q : 32'hBAD0_BAD1;
    assign bus3.ram_rdata = v3_2  ? s3_2  : 32'hBAD0_BAD3;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic req_set1(input logic [1:0] p, input logic v);
        case (p)
            PORT_LS: bus1.ls_req = v;
            PORT_VD: bus1.vd_req = v;
            default: bus1.if_req = v;
        endcase
    endtask

    // One transaction on the RAM_LAT=1 instance with cycle-exact latency checks
    task automatic txn1(input string tag, input logic [1:0] p, input logic [31:0] addr,
                        input logic we, input logic [3:0] wstrb, input logic [31:0] wdata,
                        input logic [31:0] exp_waddr, input logic [3:0] exp_we);
        case (p)
            PORT_LS: begin
                bus1.ls_addr  = addr;
                bus1.ls_we    = we;
                bus1.ls_wstrb = wstrb;
                bus1.ls_wdata = wdata;
            end
            PORT_VD: bus1.vd_addr = addr;
            default: bus1.if_addr = addr;
        endcase
        req_set1(p, 1'b1);
        tick();
        check_eq({tag, "_issue_en"}, 32'(bus1.ram_en), 32'd1);
        check_eq({tag, "_issue_addr"}, 32'(bus1.ram_addr), exp_waddr);
        check_eq({tag, "_issue_we"}, 32'(bus1.ram_we), 32'(exp_we));
        if (we) check_eq({tag, "_issue_wdata"}, bus1.ram_wdata, wdata);
        tick();
        check_eq({tag, "_wait_en_we"}, 32'({bus1.ram_en, bus1.ram_we}), 32'd0);
        check_eq({tag, "_wait_noack"}, 32'({bus1.vd_ack, bus1.ls_ack, bus1.if_ack}), 32'd0);
        tick();
        check_eq({tag, "_ack"}, 32'({bus1.vd_ack, bus1.ls_ack, bus1.if_ack}), 32'(3'b001 << p));
        tick();
        req_set1(p, 1'b0);
        check_eq({tag, "_ack_pulse"}, 32'({bus1.vd_ack, bus1.ls_ack, bus1.if_ack}), 32'd0);
    endtask

    // Pops exp_q on every ack of the RAM_LAT=1 instance until it empties or the budget runs out
    task automatic run_grants1(input string tag, input int budget);
        logic [2:0] acks;
        logic [1:0] exp_p;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            tick();
            acks = {bus1.vd_ack, bus1.ls_ack, bus1.if_ack};
            if (acks != 3'b000) begin
                exp_p = exp_q.pop_front();
                check_eq({tag, "_grant"}, 32'(acks), 32'(3'b001 << exp_p));
                tick();
                check_eq({tag, "_pulse"}, 32'({bus1.vd_ack, bus1.ls_ack, bus1.if_ack}), 32'd0);
            end
        end
        check_eq({tag, "_all_served"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bus1.if_req = 0; bus1.if_addr = 0; bus1.ls_req = 0; bus1.ls_we = 0;
        bus1.ls_wstrb = 0; bus1.ls_addr = 0; bus1.ls_wdata = 0; bus1.vd_req = 0; bus1.vd_addr = 0;
        bus3.if_req = 0; bus3.if_addr = 0; bus3.ls_req = 0; bus3.ls_we = 0;
        bus3.ls_wstrb = 0; bus3.ls_addr = 0; bus3.ls_wdata = 0; bus3.vd_req = 0; bus3.vd_addr = 0;
        RST_N = 1'b0;
        tick();
        tick();

        // reset state
        check_eq("rst_state", 32'(st1), 32'(IDLE));
        check_eq("rst_acks", 32'({bus1.vd_ack, bus1.ls_ack, bus1.if_ack}), 32'd0);
        check_eq("rst_ram_en_we", 32'({bus1.ram_en, bus1.ram_we}), 32'd0);
        check_eq("rst_ram_addr", 32'(bus1.ram_addr), 32'd0);
        check_eq("rst_ram_wdata", bus1.ram_wdata, 32'd0);
        check_eq("rst_rdata", bus1.if_rdata | bus1.ls_rdata | bus1.vd_rdata, 32'd0);
        RST_N = 1'b1;
        tick();

        // single IF reads, including ignored high/low address bits
        txn1("if_rd", PORT_IF, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'h40, 4'h0);
        check_eq("if_rd_data", bus1.if_rdata, 32'h1234_5678);
        txn1("if_wrap", PORT_IF, 32'hFFFF_0107, 1'b0, 4'h0, 32'h0, 32'h41, 4'h0);
        check_eq("if_wrap_data", bus1.if_rdata, 32'hA5A5_0041);

        // partial LS write then read back
        txn1("ls_wr", PORT_LS, 32'h8, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h2, 4'b0011);
        txn1("ls_rd", PORT_LS, 32'h8, 1'b0, 4'h0, 32'h0, 32'h2, 4'h0);
        check_eq("ls_rd_data", bus1.ls_rdata, 32'h0000_BEEF);
        check_eq("if_rdata_kept", bus1.if_rdata, 32'hA5A5_0041);

        // write with no strobes still pulses ram_en and acks, rdata untouched
        txn1("ls_nostrb", PORT_LS, 32'h8, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h2, 4'b0000);
        check_eq("ls_nostrb_rdata", bus1.ls_rdata, 32'h0000_BEEF);

        // all three requesting continuously after reset
        do_reset();
        bus1.if_addr = 32'h100; bus1.ls_addr = 32'h8; bus1.ls_we = 1'b0; bus1.vd_addr = 32'h14;
`ifdef NN_ARB_LS_PRIO_EN
        exp_q = '{PORT_LS, PORT_LS, PORT_LS, PORT_LS, PORT_LS, PORT_LS};
`else
        exp_q = '{PORT_IF, PORT_LS, PORT_VD, PORT_IF, PORT_LS, PORT_VD};
`endif
        bus1.if_req = 1'b1; bus1.ls_req = 1'b1; bus1.vd_req = 1'b1;
        run_grants1("rr3", 40);
        bus1.if_req = 1'b0; bus1.ls_req = 1'b0; bus1.vd_req = 1'b0;
`ifndef NN_ARB_LS_PRIO_EN
        check_eq("rr3_if_rdata", bus1.if_rdata, 32'h1234_5678);
        check_eq("rr3_ls_rdata", bus1.ls_rdata, 32'h0);
        check_eq("rr3_vd_rdata", bus1.vd_rdata, 32'hCAFE_F00D);
`endif
        tick();

        // LS and VD held together
        do_reset();
`ifdef NN_ARB_LS_PRIO_EN
        exp_q = '{PORT_LS, PORT_LS, PORT_LS, PORT_LS};
`else
        exp_q = '{PORT_LS, PORT_VD, PORT_LS, PORT_VD};
`endif
        bus1.ls_req = 1'b1; bus1.vd_req = 1'b1;
        run_grants1("lsvd", 30);
        bus1.ls_req = 1'b0; bus1.vd_req = 1'b0;
        tick();

        // RAM_LAT=3 VD read: ack exactly 5 cycles after req
        bus3.vd_addr = 32'h14;
        bus3.vd_req  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) check_eq("lat3_issue_addr", 32'({bus3.ram_en, bus3.ram_addr}), 32'({1'b1, 14'h5}));
            check_eq("lat3_noack_early", 32'(bus3.vd_ack), 32'd0);
        end
        tick();
        check_eq("lat3_ack", 32'(bus3.vd_ack), 32'd1);
        check_eq("lat3_vd_rdata", bus3.vd_rdata, 32'hCAFE_F00D);
        tick();
        bus3.vd_req = 1'b0;
        check_eq("lat3_ack_pulse", 32'(bus3.vd_ack), 32'd0);
        tick();

        // reset during WAIT aborts the in-flight read
        bus3.if_addr = 32'h100;
        bus3.if_req  = 1'b1;
        tick();
        check_eq("abort_issue_state", 32'(st3), 32'(ISSUE));
        tick();
        check_eq("abort_wait_state", 32'(st3), 32'(WAIT));
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        bus3.if_req = 1'b0;
        check_eq("abort_state", 32'(st3), 32'(IDLE));
        check_eq("abort_acks_en", 32'({bus3.vd_ack, bus3.ls_ack, bus3.if_ack, bus3.ram_en}), 32'd0);
        check_eq("abort_ram_addr", 32'(bus3.ram_addr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("abort_no_ack", 32'(bus3.if_ack), 32'd0);
        end
        bus3.ls_addr = 32'h8; bus3.ls_we = 1'b0;
        bus3.if_req = 1'b1; bus3.ls_req = 1'b1;
        tick();
        check_eq("abort_first_addr", 32'(bus3.ram_addr), 32'h40);
        tick(); tick(); tick(); tick();
        check_eq("abort_first_grant", 32'({bus3.vd_ack, bus3.ls_ack, bus3.if_ack}), 32'b001);
        check_eq("abort_first_rdata", bus3.if_rdata, 32'h1234_5678);
        tick();
        bus3.if_req = 1'b0; bus3.ls_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end (checks %0d)", n_checks);
        $fatal(1);
    end
endmodule
